// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data-memory req/gnt/rvalid bus between lsu and memory
interface lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  // lsu side issues requests and consumes grant/response
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  // memory side accepts requests and produces grant/response
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - multi-cycle load/store unit between exe and regs writeback
module lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // exe side
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              load_i,
  input  logic              store_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [4:0]        rd_i,
  // data-memory bus
  lsu_if.master             mem,
  // writeback side
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   rdata_o,
  output logic [4:0]        rd_o,
  output logic              wen_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;

  // latched transaction
  logic              load_q;
  logic              store_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [3:0]        mem_wstrb_q;
  logic [4:0]        rd_q;
  logic              err_q;
  logic [XLEN-1:0]   rdata_q;

  logic              accept;
  logic              mem_op;
  logic              misalign;
  logic              err_in;
  logic              capture;
  logic [XLEN-1:0]   lane_wdata;
  logic [3:0]        lane_wstrb;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_ext;

  assign accept = req_valid_i & req_ready_o;
  assign mem_op = load_i | store_i;
  assign err_in = mem_op & misalign;

  // response data/ack arrives either together with the grant or later in WAIT
  assign capture = ((state_q == S_REQ) & mem.mem_gnt & mem.mem_rvalid) |
                   ((state_q == S_WAIT) & mem.mem_rvalid);

  // alignment check on the incoming op (size 11 is always illegal)
  always_comb begin
    misalign = 1'b0;
    case (size_i)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr_i[0];
      2'b10:   misalign = |addr_i[1:0];
      default: misalign = 1'b1;
    endcase
  end

  // store data replicated across lanes so memory only needs the strobes
  always_comb begin
    lane_wdata = wdata_i;
    lane_wstrb = 4'b1111;
    case (size_i)
      2'b00: begin
        lane_wdata = {4{wdata_i[7:0]}};
        lane_wstrb = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        lane_wdata = {2{wdata_i[15:0]}};
        lane_wstrb = 4'b0011 << addr_i[1:0];
      end
      default: begin
        lane_wdata = wdata_i;
        lane_wstrb = 4'b1111;
      end
    endcase
  end

  assign shifted = mem.mem_rdata >> {off_q, 3'b000};

  // align the raw read word and extend to XLEN
  always_comb begin
    load_ext = shifted;
    case (size_q)
      2'b00:   load_ext = uns_q ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = uns_q ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // FSM state register; reset abandons any transaction in flight
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (err_in || !mem_op) state_d = S_RESP;
          else                   state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem.mem_gnt) state_d = mem.mem_rvalid ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem.mem_rvalid) state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; strobes and write-enable only shown while requesting
  always_comb begin
    req_ready_o       = (state_q == S_IDLE);
    mem.mem_req       = (state_q == S_REQ);
    mem.mem_we        = (state_q == S_REQ) & store_q;
    mem.mem_wstrb     = (state_q == S_REQ) ? mem_wstrb_q : 4'b0000;
    mem.mem_addr      = mem_addr_q;
    mem.mem_wdata     = mem_wdata_q;
    resp_valid_o      = (state_q == S_RESP);
    wen_o             = (state_q == S_RESP) & load_q & ~err_q;
    err_o             = (state_q == S_RESP) & err_q;
    rdata_o           = rdata_q;
    rd_o              = rd_q;
  end

  // latch the op on accept and the extended load data on capture
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
      rd_q        <= 5'd0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else if (accept) begin
      load_q      <= load_i;
      store_q     <= store_i;
      size_q      <= size_i;
      uns_q       <= unsigned_i;
      off_q       <= addr_i[1:0];
      mem_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
      mem_wdata_q <= lane_wdata;
      mem_wstrb_q <= store_i ? lane_wstrb : 4'b0000;
      rd_q        <= rd_i;
      err_q       <= err_in;
      rdata_q     <= '0;
    end else if (capture && load_q) begin
      rdata_q     <= load_ext;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for lsu with a scripted memory responder
module tb_lsu;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              req_valid;
  logic              req_ready_o;
  logic              load;
  logic              store;
  logic [1:0]        size;
  logic              uns;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [4:0]        rd;
  logic              resp_valid_o;
  logic              resp_ready;
  logic [XLEN-1:0]   rdata_o;
  logic [4:0]        rd_o;
  logic              wen_o;
  logic              err_o;

  lsu_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) mif ();

  lsu #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .load_i       (load),
    .store_i      (store),
    .size_i       (size),
    .unsigned_i   (uns),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rd_i         (rd),
    .mem          (mif),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready),
    .rdata_o      (rdata_o),
    .rd_o         (rd_o),
    .wen_o        (wen_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mexp_t;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        wen;
    logic        err;
  } rexp_t;

  mexp_t mq[$];
  rexp_t rq[$];

  int total = 0;
  int bad   = 0;

  int          gnt_dly    = 0;
  int          rv_dly     = 1;
  int          hold_cnt   = 0;
  logic [31:0] next_rdata = 32'h0;
  logic        mem_busy   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  req_ready_o,    1);
    check({tag, "_mem_req"},    mif.mem_req,    0);
    check({tag, "_mem_we"},     mif.mem_we,     0);
    check({tag, "_mem_wstrb"},  mif.mem_wstrb,  0);
    check({tag, "_mem_addr"},   mif.mem_addr,   0);
    check({tag, "_mem_wdata"},  mif.mem_wdata,  0);
    check({tag, "_resp_valid"}, resp_valid_o,   0);
    check({tag, "_rdata"},      rdata_o,        0);
    check({tag, "_rd"},         rd_o,           0);
    check({tag, "_wen"},        wen_o,          0);
    check({tag, "_err"},        err_o,          0);
  endtask

  // memory responder: grant after gnt_dly cycles, rvalid rv_dly cycles after grant
  initial begin
    mif.mem_gnt    = 1'b0;
    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_i && mif.mem_req) begin
        mem_busy = 1'b1;
        repeat (gnt_dly) @(negedge clk);
        mif.mem_gnt = 1'b1;
        if (rv_dly == 0) begin
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata  = next_rdata;
        end
        @(negedge clk);
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;
        if (rv_dly > 0) begin
          repeat (rv_dly - 1) @(negedge clk);
          mif.mem_rvalid = 1'b1;
          mif.mem_rdata  = next_rdata;
          @(negedge clk);
          mif.mem_rvalid = 1'b0;
        end
        mif.mem_rdata = 32'h0;
        mem_busy = 1'b0;
      end
    end
  end

  // writeback backpressure: withhold ready for hold_cnt valid cycles
  initial begin
    resp_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (resp_valid_o && hold_cnt > 0) begin
        resp_ready = 1'b0;
        hold_cnt--;
      end else begin
        resp_ready = 1'b1;
      end
    end
  end

  // memory-request monitor: every requesting cycle must match the queued expectation
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_i && mif.mem_req) begin
        if (mq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_unexpected actual_addr=%h expected=no_request", mif.mem_addr);
        end else begin
          check("mem_we",    mif.mem_we,    mq[0].we);
          check("mem_addr",  mif.mem_addr,  mq[0].addr);
          if (mq[0].we) check("mem_wdata", mif.mem_wdata, mq[0].wdata);
          check("mem_wstrb", mif.mem_wstrb, mq[0].wstrb);
          if (mif.mem_gnt) void'(mq.pop_front());
        end
      end
    end
  end

  // response monitor: outputs must hold the expected values every valid cycle
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_i && resp_valid_o) begin
        if (rq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_unexpected actual_rdata=%h expected=no_response", rdata_o);
        end else begin
          check("resp_rdata", rdata_o, rq[0].rdata);
          check("resp_rd",    rd_o,    rq[0].rd);
          check("resp_wen",   wen_o,   rq[0].wen);
          check("resp_err",   err_o,   rq[0].err);
          if (resp_ready) void'(rq.pop_front());
        end
      end
    end
  end

  task automatic wait_mem_idle(input string tag);
    int n = 0;
    while (mem_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (mem_busy) begin
      total++;
      bad++;
      $display("FAIL %s_mem_timeout actual=busy expected=idle", tag);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                       input logic mem_exp, input logic [31:0] m_addr, input logic [31:0] m_wdata,
                       input logic [3:0] m_wstrb, input logic [31:0] mem_rd,
                       input logic [31:0] r_rdata, input logic r_wen, input logic r_err);
    mexp_t me;
    rexp_t re;
    int    n;
    @(negedge clk);
    next_rdata = mem_rd;
    if (mem_exp) begin
      me.we = st; me.addr = m_addr; me.wdata = m_wdata; me.wstrb = m_wstrb;
      mq.push_back(me);
    end
    re.rdata = r_rdata; re.rd = r; re.wen = r_wen; re.err = r_err;
    rq.push_back(re);
    check("req_ready_idle", req_ready_o, 1);
    req_valid = 1'b1; load = ld; store = st; size = sz; uns = un;
    addr = a; wdata = wd; rd = r;
    @(negedge clk);
    req_valid = 1'b0; load = 1'b0; store = 1'b0;
    if (!mem_exp) begin
      check("no_mem_req",     mif.mem_req,  0);
      check("resp_next_cyc",  resp_valid_o, 1);
    end
    n = 0;
    while (rq.size() != 0 && n < 200) begin
      check("req_ready_busy", req_ready_o, 0);
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL resp_timeout actual=pending expected=done addr=%h", a);
      rq.delete();
      mq.delete();
    end
    check("req_ready_after", req_ready_o, 1);
    wait_mem_idle("issue");
  endtask

  initial begin
    mexp_t me;
    int    n;
    rst_i = 1'b0;
    req_valid = 1'b0; load = 1'b0; store = 1'b0; size = 2'b00; uns = 1'b0;
    addr = '0; wdata = '0; rd = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_i = 1'b1;

    // stores and loads with wait state between grant and rvalid
    issue(0, 1, 2'b10, 0, 32'h8000_0004, 32'hDEAD_BEEF, 5'd1, 1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h0, 0, 0);
    issue(1, 0, 2'b00, 0, 32'h8000_0003, 32'h0, 5'd2, 1, 32'h8000_0000, 32'h0, 4'b0000, 32'h8011_2233, 32'hFFFF_FF80, 1, 0);
    issue(1, 0, 2'b00, 1, 32'h8000_0003, 32'h0, 5'd3, 1, 32'h8000_0000, 32'h0, 4'b0000, 32'h8011_2233, 32'h0000_0080, 1, 0);
    issue(1, 0, 2'b01, 0, 32'h8000_0002, 32'h0, 5'd4, 1, 32'h8000_0000, 32'h0, 4'b0000, 32'h8001_1234, 32'hFFFF_8001, 1, 0);
    issue(0, 1, 2'b01, 0, 32'h8000_0002, 32'h0000_ABCD, 5'd5, 1, 32'h8000_0000, 32'hABCD_ABCD, 4'b1100, 32'h0, 32'h0, 0, 0);

    // same-cycle grant and rvalid
    rv_dly = 0;
    issue(1, 0, 2'b01, 1, 32'h0000_1000, 32'h0, 5'd6, 1, 32'h0000_1000, 32'h0, 4'b0000, 32'h1234_ABCD, 32'h0000_ABCD, 1, 0);
    issue(1, 0, 2'b01, 0, 32'h0000_1000, 32'h0, 5'd7, 1, 32'h0000_1000, 32'h0, 4'b0000, 32'h1234_ABCD, 32'hFFFF_ABCD, 1, 0);
    issue(0, 1, 2'b00, 0, 32'h0000_1001, 32'h1234_565A, 5'd8, 1, 32'h0000_1000, 32'h5A5A_5A5A, 4'b0010, 32'h0, 32'h0, 0, 0);
    issue(1, 0, 2'b10, 0, 32'h0000_1008, 32'h0, 5'd9, 1, 32'h0000_1008, 32'h0, 4'b0000, 32'h1234_5678, 32'h1234_5678, 1, 0);
    issue(1, 0, 2'b00, 0, 32'h0000_1002, 32'h0, 5'd10, 1, 32'h0000_1000, 32'h0, 4'b0000, 32'h00C3_0000, 32'hFFFF_FFC3, 1, 0);
    rv_dly = 1;

    // errors and no-op never touch memory
    issue(1, 0, 2'b10, 0, 32'h8000_0002, 32'h0, 5'd11, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 1);
    issue(1, 0, 2'b11, 0, 32'h8000_0000, 32'h0, 5'd12, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 1);
    issue(0, 1, 2'b01, 0, 32'h0000_1001, 32'hFFFF_FFFF, 5'd13, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 1);
    issue(0, 0, 2'b10, 0, 32'h0000_1000, 32'h0, 5'd14, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 0, 0);

    // backpressure on grant, rvalid and writeback
    gnt_dly = 3; rv_dly = 2; hold_cnt = 2;
    issue(1, 0, 2'b10, 0, 32'h8000_0010, 32'h0, 5'd15, 1, 32'h8000_0010, 32'h0, 4'b0000, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0);
    gnt_dly = 0; rv_dly = 1; hold_cnt = 0;

    // reset while waiting for rvalid
    rv_dly = 8;
    next_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    me.we = 1'b0; me.addr = 32'h8000_0020; me.wdata = 32'h0; me.wstrb = 4'b0000;
    mq.push_back(me);
    req_valid = 1'b1; load = 1'b1; store = 1'b0; size = 2'b10; uns = 1'b0;
    addr = 32'h8000_0020; rd = 5'd16;
    @(negedge clk);
    req_valid = 1'b0; load = 1'b0;
    @(negedge clk);
    check("wait_mem_req", mif.mem_req, 0);
    check("wait_resp_valid", resp_valid_o, 0);
    #3 rst_i = 1'b0;
    #1 check_reset_outputs("midreset");
    mq.delete();
    @(negedge clk);
    rst_i = 1'b1;
    n = 0;
    while (mem_busy && n < 50) begin
      check("stale_resp_valid", resp_valid_o, 0);
      check("stale_ready",      req_ready_o,  1);
      @(negedge clk);
      n++;
    end
    if (mem_busy) begin
      total++;
      bad++;
      $display("FAIL stale_rvalid_timeout actual=busy expected=idle");
    end
    @(negedge clk);
    check("post_stale_resp_valid", resp_valid_o, 0);
    check("post_stale_ready",      req_ready_o,  1);
    rv_dly = 1;
    issue(1, 0, 2'b10, 0, 32'h8000_0024, 32'h0, 5'd17, 1, 32'h8000_0024, 32'h0, 4'b0000, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
